// File: rtl/prog_sequencer_pkg.sv
// Shared types and widths for the program sequencer and its branch-target ROM.
package prog_sequencer_pkg;

  localparam int PC_W      = 10;
  localparam int LUT_DEPTH = 32;
  localparam int LUT_IDX_W = $clog2(LUT_DEPTH);
  localparam int CNT_W     = 16;
  localparam int PROG_W    = 2;

  typedef enum logic [1:0] {
    WAIT     = 2'd0,
    RUN      = 2'd1,
    FINISHED = 2'd2
  } seq_state_e;

  typedef logic [PC_W-1:0]      pc_t;
  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [LUT_IDX_W-1:0] lut_idx_t;
  typedef logic [PROG_W-1:0]    prog_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Bundle between the sequencer and the fetch unit / decode / ALU / bench handshake.
interface prog_sequencer_if;
  import prog_sequencer_pkg::*;

  logic     Start;
  logic     Halt;
  pc_t      PC;
  logic     Branch_req;
  lut_idx_t Lut_idx;
  logic     Flag_we;
  logic     Flag_d;

  logic     Init;
  logic     Branch_en;
  logic     FLAG_OUT;
  pc_t      Target;
  prog_t    ProgState;
  logic     Done;
  logic     Timeout;
  cnt_t     Cycles;
  pc_t      Abort_PC;

  modport master (
    input  Start, Halt, PC, Branch_req, Lut_idx, Flag_we, Flag_d,
    output Init, Branch_en, FLAG_OUT, Target, ProgState, Done, Timeout, Cycles, Abort_PC
  );

  modport slave (
    output Start, Halt, PC, Branch_req, Lut_idx, Flag_we, Flag_d,
    input  Init, Branch_en, FLAG_OUT, Target, ProgState, Done, Timeout, Cycles, Abort_PC
  );

endinterface

// File: rtl/prog_sequencer_branch_lut.sv
// Branch-target ROM: 0-7 program 0, 8-15 program 1, 16-23 program 2, 24-31 shared routines.
module branch_lut
  import prog_sequencer_pkg::*;
(
  input  lut_idx_t idx,
  output pc_t      target
);

  always_comb begin
    target = '0;
    case (idx)
      5'd0:  target = 10'h000;
      5'd1:  target = 10'h010;
      5'd2:  target = 10'h024;
      5'd3:  target = 10'h03A;
      5'd4:  target = 10'h050;
      5'd5:  target = 10'h06C;
      5'd6:  target = 10'h081;
      5'd7:  target = 10'h097;
      5'd8:  target = 10'h0A0;
      5'd9:  target = 10'h0B4;
      5'd10: target = 10'h0C8;
      5'd11: target = 10'h0DC;
      5'd12: target = 10'h0F0;
      5'd13: target = 10'h104;
      5'd14: target = 10'h118;
      5'd15: target = 10'h12C;
      5'd16: target = 10'h200;
      5'd17: target = 10'h214;
      5'd18: target = 10'h228;
      5'd19: target = 10'h23C;
      5'd20: target = 10'h250;
      5'd21: target = 10'h264;
      5'd22: target = 10'h278;
      5'd23: target = 10'h28C;
      5'd24: target = 10'h300;
      5'd25: target = 10'h320;
      5'd26: target = 10'h340;
      5'd27: target = 10'h360;
      5'd28: target = 10'h380;
      5'd29: target = 10'h3A0;
      5'd30: target = 10'h3C0;
      5'd31: target = 10'h3FF;
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/prog_sequencer.sv
// Runs NUM_PROGS programs under a Start/Done handshake, resolves branches and aborts runaways.
// state    | meaning
// WAIT     | fetch frozen, waiting for a Start rising edge
// RUN      | fetch running, cycle counter active, Halt/timeout end the program
// FINISHED | all programs done, only reset leaves
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter cnt_t MAX_CYCLES = 16'hFFFF,
  parameter int   NUM_PROGS  = 3
) (
  input logic              CLK,
  input logic              Reset_n,
  prog_sequencer_if.master bus
);

  localparam prog_t LAST_PROG = prog_t'(NUM_PROGS - 1);
  localparam cnt_t  TC_VALUE  = MAX_CYCLES - cnt_t'(1);

  seq_state_e state_q, state_d;
  logic       start_q;
  logic       flag_q;
  cnt_t       cycles_q;
  logic       done_q;
  logic       timeout_q;
  pc_t        abort_pc_q;
  prog_t      prog_q;

  logic init, branch_en;
  logic start_rise, timed_out, last_prog;
  logic in_run, run_start, end_halt, end_tmo;

  assign start_rise = bus.Start & ~start_q;
  assign timed_out  = (cycles_q == TC_VALUE);
  assign last_prog  = (prog_q == LAST_PROG);
  assign in_run     = (state_q == RUN);
  assign run_start  = (state_q == WAIT) && start_rise;
  // Halt has priority over a coincident timeout
  assign end_halt   = in_run && bus.Halt;
  assign end_tmo    = in_run && !bus.Halt && timed_out;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state_q <= WAIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:     if (start_rise) state_d = RUN;
      RUN:      if (bus.Halt || timed_out) state_d = last_prog ? FINISHED : WAIT;
      FINISHED: state_d = FINISHED;
      default:  state_d = WAIT;
    endcase
  end

  always_comb begin
    init      = 1'b1;
    branch_en = 1'b0;
    if (state_q == RUN) begin
      init      = 1'b0;
      branch_en = bus.Branch_req;
    end
  end

  // Resets high so a Start already asserted during reset is not seen as an edge
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) start_q <= 1'b1;
    else          start_q <= bus.Start;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      flag_q     <= 1'b0;
      cycles_q   <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      abort_pc_q <= '0;
      prog_q     <= '0;
    end else begin
      done_q <= end_halt || end_tmo;
      if (run_start) begin
        flag_q    <= 1'b0;
        cycles_q  <= '0;
        timeout_q <= 1'b0;
      end else if (in_run) begin
        cycles_q <= sat_inc(cycles_q);
        if (bus.Flag_we) flag_q <= bus.Flag_d;
      end
      if (end_halt) timeout_q <= 1'b0;
      if (end_tmo) begin
        timeout_q  <= 1'b1;
        abort_pc_q <= bus.PC;
      end
      if ((end_halt || end_tmo) && !last_prog) prog_q <= prog_q + prog_t'(1);
    end
  end

  branch_lut u_branch_lut (
    .idx    (bus.Lut_idx),
    .target (bus.Target)
  );

  assign bus.Init      = init;
  assign bus.Branch_en = branch_en;
  assign bus.FLAG_OUT  = flag_q;
  assign bus.ProgState = prog_q;
  assign bus.Done      = done_q;
  assign bus.Timeout   = timeout_q;
  assign bus.Cycles    = cycles_q;
  assign bus.Abort_PC  = abort_pc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench: a default-limit instance for handshake/branch/reset and a MAX_CYCLES=20 instance for timeout.
module tb_prog_sequencer;

  logic CLK = 1'b0;
  logic Reset_n;
  always #5 CLK = ~CLK;

  prog_sequencer_if bus_a();
  prog_sequencer_if bus_b();

  prog_sequencer u_dut_a (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus_a)
  );

  prog_sequencer #(.MAX_CYCLES(16'd20), .NUM_PROGS(3)) u_dut_b (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       br;
    logic [4:0] idx;
    logic       we;
    logic       d;
    logic       exp_be;
    logic [9:0] exp_tgt;
    logic       exp_fo;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_a();
    bus_a.Start = 1'b0;
    tick();
    bus_a.Start = 1'b1;
    tick();
  endtask

  task automatic start_b();
    bus_b.Start = 1'b0;
    tick();
    bus_b.Start = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
    vecs[1] = '{1'b1, 5'd7,  1'b0, 1'b0, 1'b1, 10'h097, 1'b0};
    vecs[2] = '{1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 10'h03A, 1'b0};
    vecs[3] = '{1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 10'h03A, 1'b1};
    vecs[4] = '{1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 10'h0F0, 1'b1};
    vecs[5] = '{1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 10'h3FF, 1'b0};
    vecs[6] = '{1'b0, 5'd16, 1'b1, 1'b1, 1'b0, 10'h200, 1'b0};
    vecs[7] = '{1'b1, 5'd24, 1'b1, 1'b1, 1'b1, 10'h300, 1'b1};
    vecs[8] = '{1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 10'h06C, 1'b1};

    Reset_n = 1'b1;
    bus_a.Start = 1'b1; bus_a.Halt = 1'b0; bus_a.PC = '0; bus_a.Branch_req = 1'b0;
    bus_a.Lut_idx = '0; bus_a.Flag_we = 1'b0; bus_a.Flag_d = 1'b0;
    bus_b.Start = 1'b0; bus_b.Halt = 1'b0; bus_b.PC = '0; bus_b.Branch_req = 1'b0;
    bus_b.Lut_idx = '0; bus_b.Flag_we = 1'b0; bus_b.Flag_d = 1'b0;
    #1 Reset_n = 1'b0;
    tick_n(2);

    chk("rst_init",      32'(bus_a.Init),      32'd1);
    chk("rst_branch_en", 32'(bus_a.Branch_en), 32'd0);
    chk("rst_flag_out",  32'(bus_a.FLAG_OUT),  32'd0);
    chk("rst_target",    32'(bus_a.Target),    32'h000);
    chk("rst_progstate", 32'(bus_a.ProgState), 32'd0);
    chk("rst_done",      32'(bus_a.Done),      32'd0);
    chk("rst_timeout",   32'(bus_a.Timeout),   32'd0);
    chk("rst_cycles",    32'(bus_a.Cycles),    32'd0);
    chk("rst_abort_pc",  32'(bus_a.Abort_PC),  32'd0);

    // Start held high through reset must not launch
    Reset_n = 1'b1;
    tick_n(3);
    chk("held_start_init", 32'(bus_a.Init), 32'd1);

    start_a();
    chk("p0_start_init", 32'(bus_a.Init), 32'd0);
    tick_n(39);
    chk("p0_pre_halt_done", 32'(bus_a.Done), 32'd0);
    bus_a.Halt = 1'b1;
    tick();
    bus_a.Halt = 1'b0;
    chk("p0_done",      32'(bus_a.Done),      32'd1);
    chk("p0_cycles",    32'(bus_a.Cycles),    32'd40);
    chk("p0_progstate", 32'(bus_a.ProgState), 32'd1);
    chk("p0_init",      32'(bus_a.Init),      32'd1);
    chk("p0_timeout",   32'(bus_a.Timeout),   32'd0);
    tick();
    chk("p0_done_drop",    32'(bus_a.Done),   32'd0);
    chk("p0_cycles_stable", 32'(bus_a.Cycles), 32'd40);

    start_a();
    for (int i = 0; i < 9; i++) begin
      bus_a.Branch_req = vecs[i].br;
      bus_a.Lut_idx    = vecs[i].idx;
      bus_a.Flag_we    = vecs[i].we;
      bus_a.Flag_d     = vecs[i].d;
      #1;
      chk($sformatf("vec%0d_branch_en", i), 32'(bus_a.Branch_en), 32'(vecs[i].exp_be));
      chk($sformatf("vec%0d_target", i),    32'(bus_a.Target),    32'(vecs[i].exp_tgt));
      chk($sformatf("vec%0d_flag_out", i),  32'(bus_a.FLAG_OUT),  32'(vecs[i].exp_fo));
      tick();
    end
    bus_a.Branch_req = 1'b0; bus_a.Lut_idx = '0; bus_a.Flag_we = 1'b0; bus_a.Flag_d = 1'b0;
    bus_a.Halt = 1'b1;
    tick();
    bus_a.Halt = 1'b0;
    chk("p1_done",      32'(bus_a.Done),      32'd1);
    chk("p1_cycles",    32'(bus_a.Cycles),    32'd10);
    chk("p1_progstate", 32'(bus_a.ProgState), 32'd2);

    // In WAIT: branch gated, flag write and Halt ignored, Target still live
    bus_a.Flag_we = 1'b1; bus_a.Flag_d = 1'b0; bus_a.Branch_req = 1'b1;
    bus_a.Lut_idx = 5'd3; bus_a.Halt = 1'b1;
    #1;
    chk("wait_branch_en", 32'(bus_a.Branch_en), 32'd0);
    chk("wait_target",    32'(bus_a.Target),    32'h03A);
    tick();
    chk("wait_flag_kept", 32'(bus_a.FLAG_OUT),  32'd1);
    chk("wait_halt_done", 32'(bus_a.Done),      32'd0);
    chk("wait_progstate", 32'(bus_a.ProgState), 32'd2);
    bus_a.Flag_we = 1'b0; bus_a.Branch_req = 1'b0; bus_a.Lut_idx = '0; bus_a.Halt = 1'b0;

    start_a();
    chk("p2_flag_cleared", 32'(bus_a.FLAG_OUT), 32'd0);
    tick_n(4);
    bus_a.Halt = 1'b1;
    tick();
    bus_a.Halt = 1'b0;
    chk("p2_done",      32'(bus_a.Done),      32'd1);
    chk("p2_cycles",    32'(bus_a.Cycles),    32'd5);
    chk("p2_progstate", 32'(bus_a.ProgState), 32'd2);
    chk("p2_init",      32'(bus_a.Init),      32'd1);

    for (int k = 0; k < 3; k++) begin
      start_a();
      chk($sformatf("fin%0d_init", k), 32'(bus_a.Init), 32'd1);
      tick();
      chk($sformatf("fin%0d_done", k), 32'(bus_a.Done), 32'd0);
    end

    // New session, abort program 1 by reset at cycle 7
    Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
    start_a();
    tick_n(2);
    bus_a.Halt = 1'b1;
    tick();
    bus_a.Halt = 1'b0;
    chk("s2_p0_progstate", 32'(bus_a.ProgState), 32'd1);
    start_a();
    tick_n(7);
    chk("mid_cycles", 32'(bus_a.Cycles), 32'd7);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_init",      32'(bus_a.Init),      32'd1);
    chk("mid_rst_progstate", 32'(bus_a.ProgState), 32'd0);
    chk("mid_rst_cycles",    32'(bus_a.Cycles),    32'd0);
    #2 Reset_n = 1'b1;
    tick();
    chk("post_rst_init", 32'(bus_a.Init), 32'd1);
    start_a();
    chk("restart_init",      32'(bus_a.Init),      32'd0);
    chk("restart_progstate", 32'(bus_a.ProgState), 32'd0);
    tick_n(2);
    bus_a.Halt = 1'b1;
    tick();
    bus_a.Halt = 1'b0;
    chk("restart_done",      32'(bus_a.Done),      32'd1);
    chk("restart_cycles",    32'(bus_a.Cycles),    32'd3);
    chk("restart_progstate", 32'(bus_a.ProgState), 32'd1);

    // Timeout instance, MAX_CYCLES = 20
    bus_b.PC = 10'h1AA;
    start_b();
    chk("b0_init", 32'(bus_b.Init), 32'd0);
    tick_n(19);
    chk("b0_pre_cycles", 32'(bus_b.Cycles), 32'd19);
    chk("b0_pre_done",   32'(bus_b.Done),   32'd0);
    bus_b.PC = 10'h055;
    tick();
    bus_b.PC = 10'h0FF;
    chk("b0_done",      32'(bus_b.Done),      32'd1);
    chk("b0_timeout",   32'(bus_b.Timeout),   32'd1);
    chk("b0_abort_pc",  32'(bus_b.Abort_PC),  32'h055);
    chk("b0_progstate", 32'(bus_b.ProgState), 32'd1);
    chk("b0_init",      32'(bus_b.Init),      32'd1);
    chk("b0_cycles",    32'(bus_b.Cycles),    32'd20);
    tick();
    chk("b0_done_drop",    32'(bus_b.Done),     32'd0);
    chk("b0_abort_pc_hold", 32'(bus_b.Abort_PC), 32'h055);

    start_b();
    chk("b1_timeout_clr", 32'(bus_b.Timeout), 32'd0);
    tick_n(19);
    bus_b.Halt = 1'b1;
    bus_b.PC = 10'h077;
    tick();
    bus_b.Halt = 1'b0;
    chk("b1_done",      32'(bus_b.Done),      32'd1);
    chk("b1_timeout",   32'(bus_b.Timeout),   32'd0);
    chk("b1_abort_pc",  32'(bus_b.Abort_PC),  32'h055);
    chk("b1_progstate", 32'(bus_b.ProgState), 32'd2);

    start_b();
    tick();
    bus_b.Halt = 1'b1;
    tick();
    bus_b.Halt = 1'b0;
    chk("b2_done",      32'(bus_b.Done),      32'd1);
    chk("b2_progstate", 32'(bus_b.ProgState), 32'd2);
    chk("b2_init",      32'(bus_b.Init),      32'd1);
    start_b();
    tick();
    chk("b_fin_done", 32'(bus_b.Done), 32'd0);
    chk("b_fin_init", 32'(bus_b.Init), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program sequencer on the control side of the instruction-fetch interface: drives the fetch unit's Init, Branch_en, FLAG_IN, Target and ProgState, and consumes its PC and Halt. Runs three programs in order under a Start/Done handshake with the bench, resolves conditional branches through a target lookup table and a registered condition flag, counts cycles per program, and aborts a runaway program on timeout.

## Interface
- MAX_CYCLES, default 16'hFFFF: RUN-cycle limit per program before forced abort.
- NUM_PROGS, default 3: programs per session; ProgState runs 0..NUM_PROGS-1.
- CLK  input  1  clock; all state changes on posedge.
- Reset_n  input  1  reset, asynchronous, active-low.
- Start  input  1  level request from bench; a low-to-high transition starts the next program.
- Halt  input  1  fetch unit's done flag (one-cycle pulse).
- PC  input  10  fetch unit's program counter; used only for the Abort_PC capture.
- Branch_req  input  1  decode: current instruction is a conditional branch.
- Lut_idx  input  5  decode: branch-target LUT index.
- Flag_we  input  1  ALU: write condition flag this cycle.
- Flag_d  input  1  ALU: condition flag value.
- Init  output  1  fetch hold; 1 = fetch frozen.
- Branch_en  output  1  to fetch.
- FLAG_OUT  output  1  to fetch FLAG_IN.
- Target  output  10  to fetch.
- ProgState  output  2  current program index.
- Done  output  1  one-cycle pulse at program end.
- Timeout  output  1  valid with Done: program was aborted.
- Cycles  output  16  RUN cycles of the last/current program.
- Abort_PC  output  10  PC captured on timeout.

## Operation
- States: WAIT, RUN, FINISHED. Reset enters WAIT.
- Reset values: Init=1, Branch_en=0, FLAG_OUT=0, Target=LUT[0], ProgState=0, Done=0, Timeout=0, Cycles=0, Abort_PC=0. The Start edge register resets to 1, so a Start held high through reset does not launch a program.
- WAIT: Init=1.
  - Start=1 while the registered previous Start=0 → RUN.
  - On that transition: Cycles←0, flag←0, Timeout←0.
- RUN: Init=0. Cycles increments each cycle, saturating at 16'hFFFF.
  - Flag_we=1 → flag←Flag_d.
  - Branch_en = Branch_req in RUN; 0 in all other states.
  - FLAG_OUT = registered flag, so a branch sees the flag written in a prior cycle, never the same cycle.
  - Target = LUT[Lut_idx], combinational in every state.
  - Halt=1 → Done=1 for the next cycle, Timeout=0.
  - Otherwise, Cycles==MAX_CYCLES-1 → Done=1 for the next cycle, Timeout=1, Abort_PC←PC.
  - If Halt and the timeout condition occur in the same cycle, Halt wins and Timeout=0.
  - After either end condition:
    - ProgState < NUM_PROGS-1 → ProgState+1, enter WAIT.
    - ProgState = NUM_PROGS-1 → ProgState holds, enter FINISHED.
- FINISHED: Init=1. Start is ignored. Only Reset_n leaves this state.
- Halt outside RUN is ignored.
- Flag_we outside RUN is ignored.
- Reset mid-RUN: all outputs return to reset values asynchronously; the in-flight program is discarded.

## Timing
- Start rising sampled at edge N → Init=0 after edge N; fetch advances from edge N+1.
- Halt high at edge M → after edge M: Init=1, Done=1, ProgState updated. Done drops after edge M+1.
- The fetch unit may advance PC once on the Halt edge. This is accepted.
- Cycles is stable from Done until the next Start edge.
- Branch path (Lut_idx→Target, Branch_req→Branch_en) is combinational, zero latency.

## Structure
- Shared package holds:
  - state enum {WAIT, RUN, FINISHED};
  - PC width 10, LUT depth 32, counter width 16.
- Sub-module branch_lut: 32×10 combinational ROM, contents per program set.
- Remaining logic (FSM, flag register, counter, Start edge detect) stays in prog_sequencer.

## Test plan
- Reset with Start=1 held → stays in WAIT, Init=1 until Start drops and rises again.
- Start edge, Halt pulsed 40 cycles later → Done one cycle, Cycles=40, ProgState 0→1, Init=1 next cycle.
- RUN, Flag_we=1/Flag_d=1 at cycle 5, Branch_req=1 with Lut_idx=3 at cycle 6 → Branch_en=1, FLAG_OUT=1, Target=LUT[3]. Flag_we and Branch_req in the same cycle → FLAG_OUT shows the old flag.
- MAX_CYCLES=20, no Halt, PC=10'h055 at cycle 19 → Done with Timeout=1, Abort_PC=10'h055, ProgState advances.
- Halt coinciding with the timeout cycle → Timeout=0. Three programs completed → FINISHED, further Start edges produce no Done.
- Reset_n low mid-RUN at cycle 7 → immediate Init=1, ProgState=0, Cycles=0. A fresh Start edge restarts program 0.
